freelist: RTL and testbench

- Physical-register free list and allocator for the 4-wide rename stage.
- Hands out up to 4 free physical register tags per cycle to rename and drives the matching set addresses to the busy table, marking new destinations busy.
- Accepts up to 4 released tags per cycle from commit and recycles them.
- Circular buffer of tags; tag 0 is the hardwired zero register and is never stored, allocated or freed.

---
 rtl/rename_pkg.sv | 19 +
 rtl/freelist_compact.sv | 42 ++++
 rtl/freelist.sv | 77 +++++++
 tb/tb_freelist.sv | 129 ++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// Shared rename-stage definitions: lane count, default sizes and small bus helpers.
package rename_pkg;
  localparam int LANES     = 4;
  localparam int DEF_WIDTH = 6;
  localparam int DEF_NARCH = 32;
  localparam int MAXW      = 16;

  // Extract lane k of a LANES*w bus that has been zero-extended to LANES*MAXW bits.
  function automatic logic [MAXW-1:0] lane_slice(input logic [LANES*MAXW-1:0] bus,
                                                 input int w, input int k);
    logic [LANES*MAXW-1:0] sh;
    sh = bus >> (k * w);
    return sh[MAXW-1:0] & ((MAXW'(1) << w) - MAXW'(1));
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction
endpackage

// File: rtl/freelist_compact.sv
// Packs the valid, non-zero released tags into the low lanes, preserving lane order.
module freelist_compact
  import rename_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [LANES-1:0]       i_free_en,
  input  logic [LANES*WIDTH-1:0] i_free_addr4x,
  output logic [LANES*WIDTH-1:0] o_tags4x,
  output logic [2:0]             o_cnt
);
  logic [LANES*MAXW-1:0]         bus;
  logic [LANES-1:0][WIDTH-1:0]   tag_in;
  logic [LANES-1:0][WIDTH-1:0]   tag_out;
  logic [LANES-1:0]              eff;
  logic [LANES-1:0][2:0]         pos;

  assign bus = (LANES*MAXW)'(i_free_addr4x);

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      tag_in[k] = WIDTH'(lane_slice(bus, WIDTH, k));
      eff[k]    = i_free_en[k] && (tag_in[k] != '0);
    end
  end

  // pos[k] = number of effective lanes below k, i.e. the output slot lane k lands in
  always_comb begin
    pos[0] = 3'd0;
    for (int k = 1; k < LANES; k++) pos[k] = pos[k-1] + 3'(eff[k-1]);
  end

  always_comb begin
    tag_out = '0;
    for (int j = 0; j < LANES; j++)
      for (int k = 0; k < LANES; k++)
        if (eff[k] && pos[k] == 3'(j)) tag_out[j] = tag_in[k];
  end

  assign o_tags4x = tag_out;
  assign o_cnt    = popcount4(eff);
endmodule

// File: rtl/freelist.sv
// Physical-register free list: circular tag buffer, 4-wide zero-latency allocate, 4-wide release.
module freelist
  import rename_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NARCH = DEF_NARCH
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [2:0]             i_alloc_cnt,
  output logic                   o_alloc_ok,
  output logic [LANES*WIDTH-1:0] o_alloc_addr4x,
  output logic [LANES*WIDTH-1:0] o_setAddr4x,
  input  logic [LANES-1:0]       i_free_en,
  input  logic [LANES*WIDTH-1:0] i_free_addr4x,
  output logic [WIDTH:0]         o_count,
  output logic                   o_empty,
  output logic                   o_overflow
);
  localparam int SIZE  = 2**WIDTH;
  localparam int NFREE = SIZE - NARCH;

  logic [WIDTH-1:0]            mem [SIZE];
  logic [WIDTH:0]              head, tail, count;
  logic                        ovf;
  logic [2:0]                  req, gcnt, fcnt;
  logic                        grant;
  logic [LANES-1:0][WIDTH-1:0] head_tag, set_tag, ftag;
  logic [LANES*WIDTH-1:0]      ftags4x;
  logic [WIDTH+1:0]            count_nxt;

  freelist_compact #(.WIDTH(WIDTH)) u_compact (
    .i_free_en    (i_free_en),
    .i_free_addr4x(i_free_addr4x),
    .o_tags4x     (ftags4x),
    .o_cnt        (fcnt)
  );

  assign ftag       = ftags4x;
  assign req        = (i_alloc_cnt <= 3'd4) ? i_alloc_cnt : 3'd0;
  assign o_alloc_ok = count >= (WIDTH+1)'(req);
  // No busy-table sets go out while reset is held
  assign grant      = o_alloc_ok && (req != 3'd0) && i_rst_n;
  assign gcnt       = grant ? req : 3'd0;

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      head_tag[k] = mem[head[WIDTH-1:0] + WIDTH'(k)];
      set_tag[k]  = (grant && 3'(k) < req) ? head_tag[k] : '0;
    end
  end

  assign o_alloc_addr4x = head_tag;
  assign o_setAddr4x    = set_tag;
  assign count_nxt      = (WIDTH+2)'(count) - (WIDTH+2)'(gcnt) + (WIDTH+2)'(fcnt);
  assign o_count        = count;
  assign o_empty        = (count == '0);
  assign o_overflow     = ovf;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SIZE; i++) mem[i] <= (i < NFREE) ? WIDTH'(NARCH + i) : '0;
      head  <= '0;
      tail  <= (WIDTH+1)'(NFREE);
      count <= (WIDTH+1)'(NFREE);
      ovf   <= 1'b0;
    end else begin
      for (int j = 0; j < LANES; j++)
        if (3'(j) < fcnt) mem[tail[WIDTH-1:0] + WIDTH'(j)] <= ftag[j];
      head  <= head + (WIDTH+1)'(gcnt);
      tail  <= tail + (WIDTH+1)'(fcnt);
      count <= count_nxt[WIDTH:0];
      // Releasing more than can ever be outstanding means commit returned a tag twice
      if (count_nxt > (WIDTH+2)'(NFREE)) ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_freelist.sv
// Directed bench for freelist: a vector table for the alloc/free flow plus overflow and async reset sequences.
module tb_freelist;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  alloc_cnt = '0;
  logic        alloc_ok;
  logic [23:0] alloc_addr4x, set_addr4x;
  logic [3:0]  free_en = '0;
  logic [23:0] free_addr4x = '0;
  logic [6:0]  count;
  logic        empty, overflow;

  int checks = 0;
  int errors = 0;

  freelist #(.WIDTH(6), .NARCH(32)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_alloc_cnt   (alloc_cnt),
    .o_alloc_ok    (alloc_ok),
    .o_alloc_addr4x(alloc_addr4x),
    .o_setAddr4x   (set_addr4x),
    .i_free_en     (free_en),
    .i_free_addr4x (free_addr4x),
    .o_count       (count),
    .o_empty       (empty),
    .o_overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  a_cnt;
    logic [3:0]  f_en;
    logic [23:0] f_addr;
    logic        x_ok;
    logic [23:0] x_addr;
    logic [23:0] x_set;
    logic [6:0]  x_count;
    logic        x_empty;
    logic        x_ovf;
  } vec_t;

  vec_t vec [16];

  function automatic logic [23:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ok, input logic [23:0] addr,
                         input logic [23:0] set, input logic [6:0] cnt,
                         input logic emp, input logic ovf);
    chk({tag, ".ok"},    32'(alloc_ok),     32'(ok));
    chk({tag, ".addr"},  32'(alloc_addr4x), 32'(addr));
    chk({tag, ".set"},   32'(set_addr4x),   32'(set));
    chk({tag, ".count"}, 32'(count),        32'(cnt));
    chk({tag, ".empty"}, 32'(empty),        32'(emp));
    chk({tag, ".ovf"},   32'(overflow),     32'(ovf));
  endtask

  task automatic drive(input logic [2:0] a, input logic [3:0] e, input logic [23:0] f);
    alloc_cnt = a; free_en = e; free_addr4x = f;
  endtask

  initial begin
    vec[0] = '{3'd0, 4'b0000, 24'd0, 1'b1, pk(32,33,34,35), 24'd0, 7'd32, 1'b0, 1'b0};
    for (int n = 0; n < 8; n++)
      vec[1+n] = '{3'd4, 4'b0000, 24'd0, 1'b1, pk(32+4*n, 33+4*n, 34+4*n, 35+4*n),
                   pk(32+4*n, 33+4*n, 34+4*n, 35+4*n), 7'(32-4*n), 1'b0, 1'b0};
    vec[9]  = '{3'd1, 4'b0000, 24'd0, 1'b0, 24'd0, 24'd0, 7'd0, 1'b1, 1'b0};
    vec[10] = '{3'd0, 4'b1010, pk(0,40,0,33), 1'b1, 24'd0, 24'd0, 7'd0, 1'b1, 1'b0};
    vec[11] = '{3'd1, 4'b0011, pk(0,45,0,0), 1'b1, pk(40,33,0,0), pk(40,0,0,0), 7'd2, 1'b0, 1'b0};
    vec[12] = '{3'd3, 4'b0101, pk(50,7,51,9), 1'b0, pk(33,45,0,0), 24'd0, 7'd2, 1'b0, 1'b0};
    vec[13] = '{3'd3, 4'b0000, 24'd0, 1'b1, pk(33,45,50,51), pk(33,45,50,0), 7'd4, 1'b0, 1'b0};
    vec[14] = '{3'd7, 4'b0000, 24'd0, 1'b1, pk(51,0,0,0), 24'd0, 7'd1, 1'b0, 1'b0};
    vec[15] = '{3'd5, 4'b0000, 24'd0, 1'b1, pk(51,0,0,0), 24'd0, 7'd1, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk_all("reset_held", 1'b1, pk(32,33,34,35), 24'd0, 7'd32, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      drive(vec[i].a_cnt, vec[i].f_en, vec[i].f_addr);
      #3;
      chk_all($sformatf("vec%0d", i), vec[i].x_ok, vec[i].x_addr, vec[i].x_set,
              vec[i].x_count, vec[i].x_empty, vec[i].x_ovf);
    end

    // Refill to exactly 32 free tags: head=36 holds 51, tail wraps past the top of the buffer
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      drive(3'd0, 4'b1111, pk(4*c+1, 4*c+2, 4*c+3, 4*c+4));
      #3; chk($sformatf("fill%0d.count", c), 32'(count), 32'(1 + 4*c));
    end
    @(posedge clk); #1; drive(3'd0, 4'b0111, pk(29,30,31,0));
    #3; chk("fill7.count", 32'(count), 32'd29);
    @(posedge clk); #1; drive(3'd0, 4'b0000, 24'd0);
    #3; chk_all("full", 1'b1, pk(51,1,2,3), 24'd0, 7'd32, 1'b0, 1'b0);
    @(posedge clk); #1; drive(3'd0, 4'b0001, pk(5,0,0,0));
    #3; chk("ovf_pre", 32'(overflow), 32'd0);
    @(posedge clk); #1; drive(3'd0, 4'b0000, 24'd0);
    #3; chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd33);
    @(posedge clk); #1;
    #3; chk("ovf_sticky", 32'(overflow), 32'd1);

    // Asynchronous reset between edges with a request held on the port
    @(posedge clk); #1; drive(3'd4, 4'b0000, 24'd0);
    #1; rst_n = 1'b0;
    #1; chk_all("async_rst", 1'b1, pk(32,33,34,35), 24'd0, 7'd32, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    #1; chk("post_rst.set", 32'(set_addr4x), 32'(pk(32,33,34,35)));
    @(posedge clk); #1; drive(3'd0, 4'b0000, 24'd0);
    #3; chk("post_rst.count", 32'(count), 32'd28);
    chk("post_rst.addr", 32'(alloc_addr4x), 32'(pk(36,37,38,39)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
